gpcfg_ahb_if: RTL and testbench

AHB-Lite slave front-end for the general-purpose config register bank. It converts pipelined AHB address/data phases into single-cycle write strobes and read-select strobes for the per-register read/write slices. It collects the OR-combined read data from those slices and returns it on hrdata with one wait state. Protocol errors (unsupported or misaligned size) get a two-cycle ERROR response with no register side effects.

---
 rtl/gpcfg_ahb_if.sv | 125 ++++++++++++
 tb/tb_gpcfg_ahb_if.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpcfg_ahb_if.sv
`default_nettype none
//==============================================================================
// Module      : gpcfg_ahb_if
// Description : AHB-Lite slave front-end for the general-purpose config bank.
//               Turns address/data phases into write/read-select strobes and
//               returns OR-combined slice read data with one wait state.
// Revision    : 1.0 - initial release
//==============================================================================
module gpcfg_ahb_if #(
   parameter logic [31:0] ADDR_MASK       = 32'h0000_FFFF,
   parameter bit          ERR_ON_MISALIGN = 1'b1
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   output logic        wr_en,
   output logic [3:0]  byte_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wdata,
   output logic        rd_en,
   output logic [31:0] rd_addr,
   input  logic [31:0] rdata_in
);

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_wr   = 3'd1;
   localparam logic [2:0] c_st_rd1  = 3'd2;
   localparam logic [2:0] c_st_rd2  = 3'd3;
   localparam logic [2:0] c_st_err1 = 3'd4;
   localparam logic [2:0] c_st_err2 = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic [1:0]  r_size;
   logic [31:0] r_wr_addr;
   logic [31:0] r_rd_addr;
   logic [31:0] r_hrdata;
   logic        w_can_accept;
   logic        w_accept;
   logic        w_misalign;
   logic        w_illegal;
   logic [31:0] w_addr_in;
   logic [3:0]  w_byte_en;
   logic        w_unused;

   assign w_unused = htrans[0];

   // A new address phase is only taken in cycles where this slave drives hreadyout high
   assign w_can_accept = (r_state == c_st_idle) | (r_state == c_st_wr) |
                         (r_state == c_st_rd2)  | (r_state == c_st_err2);
   assign w_accept     = w_can_accept & hsel & hready & htrans[1];

   assign w_misalign = ((hsize == 3'd1) & haddr[0]) |
                       ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
   assign w_illegal  = (hsize > 3'd2) | (ERR_ON_MISALIGN & w_misalign);
   assign w_addr_in  = (w_misalign ? {haddr[31:2], 2'b00} : haddr) & ADDR_MASK;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_rd1:  w_state_nxt = c_st_rd2;
         c_st_err1: w_state_nxt = c_st_err2;
         default: begin
            if (w_accept) begin
               if (w_illegal)   w_state_nxt = c_st_err1;
               else if (hwrite) w_state_nxt = c_st_wr;
               else             w_state_nxt = c_st_rd1;
            end else begin
               w_state_nxt = c_st_idle;
            end
         end
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state   <= c_st_idle;
         r_size    <= 2'd0;
         r_wr_addr <= 32'h0;
         r_rd_addr <= 32'h0;
         r_hrdata  <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         // Separate address registers let each bus hold its last value while idle
         if (w_accept & ~w_illegal) begin
            r_size <= hsize[1:0];
            if (hwrite) r_wr_addr <= w_addr_in;
            else        r_rd_addr <= w_addr_in;
         end
         if (r_state == c_st_rd1) r_hrdata <= rdata_in;
      end
   end

   always_comb begin
      w_byte_en = 4'b0000;
      if (r_state == c_st_wr) begin
         case (r_size)
            2'd0:    w_byte_en = 4'b0001 << r_wr_addr[1:0];
            2'd1:    w_byte_en = 4'b0011 << {r_wr_addr[1], 1'b0};
            default: w_byte_en = 4'b1111;
         endcase
      end
   end

   assign hreadyout = ~((r_state == c_st_rd1) | (r_state == c_st_err1));
   assign hresp     = (r_state == c_st_err1) | (r_state == c_st_err2);
   assign hrdata    = r_hrdata;
   assign wr_en     = (r_state == c_st_wr);
   assign byte_en   = w_byte_en;
   assign wr_addr   = r_wr_addr;
   assign wdata     = hwdata;
   assign rd_en     = (r_state == c_st_rd1);
   assign rd_addr   = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_gpcfg_ahb_if.sv
`default_nettype none
//==============================================================================
// Module      : tb_gpcfg_ahb_if
// Description : Scoreboard bench for gpcfg_ahb_if with a small register model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_gpcfg_ahb_if;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic        wr_en;
   logic [3:0]  byte_en;
   logic [31:0] wr_addr;
   logic [31:0] wdata;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic [31:0] rdata_in;

   typedef struct packed {
      logic        is_wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] last_wr_addr = 32'h0;

   logic [31:0] mem [0:15];
   logic        ovr_en;
   logic [31:0] ovr_val;

   always #5 hclk = ~hclk;

   gpcfg_ahb_if #(
      .ADDR_MASK       (32'h0000_FFFF),
      .ERR_ON_MISALIGN (1'b1)
   ) u_dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hready    (hready),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .wr_en     (wr_en),
      .byte_en   (byte_en),
      .wr_addr   (wr_addr),
      .wdata     (wdata),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rdata_in  (rdata_in)
   );

   // Register-slice model: byte-lane writes, zero contribution when not selected
   always_ff @(posedge hclk) begin
      if (hreset) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (byte_en[b]) mem[wr_addr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata_in = !rd_en ? 32'h0 : (ovr_en ? ovr_val : mem[rd_addr[5:2]]);

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hready = 1'b1;
   endtask

   task automatic drive_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
      hsel   = 1'b1;
      htrans = 2'b10;
      hwrite = wr;
      haddr  = a;
      hsize  = sz;
      hready = 1'b1;
   endtask

   task automatic test_reset();
      hreset = 1'b1;
      drive_idle();
      haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
      ovr_en = 1'b0; ovr_val = 32'h0;
      step();
      step();
      n_checks++;
      if ({hreadyout, hresp, wr_en, rd_en, byte_en} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_ctl: got rdy=%b resp=%b wr=%b rd=%b be=%b, expected 1 0 0 0 0000",
                  hreadyout, hresp, wr_en, rd_en, byte_en);
      end
      n_checks++;
      if ({hrdata, wr_addr, rd_addr} !== 96'h0) begin
         n_fail++;
         $display("FAIL reset_regs: got hrdata=%h wr_addr=%h rd_addr=%h, expected all 0",
                  hrdata, wr_addr, rd_addr);
      end
      hreset = 1'b0;
      // BUSY with hsel must be ignored
      hsel = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
      step();
      step();
      n_checks++;
      if ({hreadyout, hresp, wr_en, rd_en, byte_en} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL idle_busy: got rdy=%b resp=%b wr=%b rd=%b be=%b, expected 1 0 0 0 0000",
                  hreadyout, hresp, wr_en, rd_en, byte_en);
      end
      drive_idle();
      step();
   endtask

   task automatic test_word_write();
      exp_t e;
      int   cyc;
      sb_q.push_back('{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF});
      drive_addr(1'b1, 32'h4000_0010, 3'd2);
      step();
      drive_idle();
      hwdata = 32'hDEAD_BEEF;
      #1;
      cyc = 0;
      while (wr_en !== 1'b1 && cyc < 4) begin step(); cyc++; end
      n_checks++;
      if (wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL word_write_strobe: got wr_en=%b, expected 1 within 4 cycles", wr_en);
      end else begin
         e = sb_q.pop_front();
         n_checks++;
         if ({wr_addr, byte_en, wdata, hreadyout, rd_en} !== {e.addr, e.be, e.data, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL word_write: got addr=%h be=%h data=%h rdy=%b rd=%b, expected %h %h %h 1 0",
                     wr_addr, byte_en, wdata, hreadyout, rd_en, e.addr, e.be, e.data);
         end
         last_wr_addr = e.addr;
      end
      step();
      n_checks++;
      if ({wr_en, byte_en} !== 5'b0_0000) begin
         n_fail++;
         $display("FAIL word_write_single: got wr_en=%b be=%b, expected 0 0000", wr_en, byte_en);
      end
   endtask

   task automatic test_word_read();
      exp_t e;
      ovr_en  = 1'b1;
      ovr_val = 32'h1234_5678;
      sb_q.push_back('{1'b0, 32'h0000_0010, 4'h0, 32'h1234_5678});
      drive_addr(1'b0, 32'h0000_0010, 3'd2);
      step();
      drive_idle();
      n_checks++;
      if ({rd_en, wr_en, hreadyout, rd_addr} !== {1'b1, 1'b0, 1'b0, 32'h0000_0010}) begin
         n_fail++;
         $display("FAIL read_rd1: got rd=%b wr=%b rdy=%b rd_addr=%h, expected 1 0 0 00000010",
                  rd_en, wr_en, hreadyout, rd_addr);
      end
      step();
      e = sb_q.pop_front();
      n_checks++;
      if ({rd_en, hreadyout, hrdata} !== {1'b0, 1'b1, e.data}) begin
         n_fail++;
         $display("FAIL read_rd2: got rd=%b rdy=%b hrdata=%h, expected 0 1 %h",
                  rd_en, hreadyout, hrdata, e.data);
      end
      ovr_en = 1'b0;
      step();
      n_checks++;
      if ({hrdata, wr_addr} !== {32'h1234_5678, last_wr_addr}) begin
         n_fail++;
         $display("FAIL read_hold: got hrdata=%h wr_addr=%h, expected 12345678 %h",
                  hrdata, wr_addr, last_wr_addr);
      end
   endtask

   task automatic test_byte_half_writes();
      logic [31:0] a_tbl  [3];
      logic [31:0] m_tbl  [3];
      logic [2:0]  s_tbl  [3];
      logic [3:0]  be_tbl [3];
      exp_t        e;
      int          cyc;
      logic [31:0] d;
      a_tbl  = '{32'h4000_0013, 32'h4000_0012, 32'h0000_0105};
      m_tbl  = '{32'h0000_0013, 32'h0000_0012, 32'h0000_0105};
      s_tbl  = '{3'd0, 3'd1, 3'd0};
      be_tbl = '{4'b1000, 4'b1100, 4'b0010};
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         sb_q.push_back('{1'b1, m_tbl[i], be_tbl[i], d});
         drive_addr(1'b1, a_tbl[i], s_tbl[i]);
         step();
         drive_idle();
         hwdata = d;
         #1;
         cyc = 0;
         while (wr_en !== 1'b1 && cyc < 4) begin step(); cyc++; end
         n_checks++;
         if (wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL subword_strobe[%0d]: got wr_en=%b, expected 1 within 4 cycles", i, wr_en);
         end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({wr_addr, byte_en, wdata} !== {e.addr, e.be, e.data}) begin
               n_fail++;
               $display("FAIL subword_write[%0d]: got addr=%h be=%b data=%h, expected %h %b %h",
                        i, wr_addr, byte_en, wdata, e.addr, e.be, e.data);
            end
            last_wr_addr = e.addr;
         end
         step();
      end
   endtask

   task automatic test_errors();
      logic [31:0] a_tbl [3];
      logic [2:0]  s_tbl [3];
      logic        w_tbl [3];
      a_tbl = '{32'h0000_0002, 32'h0000_0010, 32'h0000_0001};
      s_tbl = '{3'd2, 3'd3, 3'd1};
      w_tbl = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive_addr(w_tbl[i], a_tbl[i], s_tbl[i]);
         step();
         drive_idle();
         hwdata = 32'hFFFF_FFFF;
         n_checks++;
         if ({hresp, hreadyout, wr_en, rd_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL err1[%0d]: got resp=%b rdy=%b wr=%b rd=%b, expected 1 0 0 0",
                     i, hresp, hreadyout, wr_en, rd_en);
         end
         step();
         n_checks++;
         if ({hresp, hreadyout, wr_en, rd_en} !== 4'b1100) begin
            n_fail++;
            $display("FAIL err2[%0d]: got resp=%b rdy=%b wr=%b rd=%b, expected 1 1 0 0",
                     i, hresp, hreadyout, wr_en, rd_en);
         end
         step();
         n_checks++;
         if ({hresp, hreadyout, wr_en, rd_en, byte_en, wr_addr} !==
             {1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, last_wr_addr}) begin
            n_fail++;
            $display("FAIL err_done[%0d]: got resp=%b rdy=%b wr=%b rd=%b be=%b wr_addr=%h, expected 0 1 0 0 0000 %h",
                     i, hresp, hreadyout, wr_en, rd_en, byte_en, wr_addr, last_wr_addr);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a_tbl [2];
      logic [31:0] d_tbl [2];
      exp_t        e;
      a_tbl = '{32'h0000_0020, 32'h0000_0024};
      d_tbl = '{32'hA5A5_0F0F, 32'h1357_9BDF};
      drive_addr(1'b1, a_tbl[0], 3'd2);
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back('{1'b1, a_tbl[i], 4'hF, d_tbl[i]});
         sb_q.push_back('{1'b0, a_tbl[i], 4'h0, d_tbl[i]});
         step();
         // Read address phase overlaps the write data phase
         hwdata = d_tbl[i];
         drive_addr(1'b0, a_tbl[i], 3'd2);
         #1;
         e = sb_q.pop_front();
         n_checks++;
         if ({wr_en, hreadyout, wr_addr, byte_en, wdata} !== {1'b1, 1'b1, e.addr, e.be, e.data}) begin
            n_fail++;
            $display("FAIL b2b_write[%0d]: got wr=%b rdy=%b addr=%h be=%h data=%h, expected 1 1 %h %h %h",
                     i, wr_en, hreadyout, wr_addr, byte_en, wdata, e.addr, e.be, e.data);
         end
         step();
         drive_idle();
         n_checks++;
         if ({rd_en, wr_en, hreadyout, rd_addr} !== {1'b1, 1'b0, 1'b0, a_tbl[i]}) begin
            n_fail++;
            $display("FAIL b2b_rd1[%0d]: got rd=%b wr=%b rdy=%b rd_addr=%h, expected 1 0 0 %h",
                     i, rd_en, wr_en, hreadyout, rd_addr, a_tbl[i]);
         end
         step();
         e = sb_q.pop_front();
         n_checks++;
         if ({rd_en, hreadyout, hrdata} !== {1'b0, 1'b1, e.data}) begin
            n_fail++;
            $display("FAIL b2b_read[%0d]: got rd=%b rdy=%b hrdata=%h, expected 0 1 %h",
                     i, rd_en, hreadyout, hrdata, e.data);
         end
         // Next write address phase issued from RD2
         if (i == 0) drive_addr(1'b1, a_tbl[1], 3'd2);
      end
      step();
      // Reset lands while a read sits in RD1: transfer is dropped
      drive_addr(1'b0, a_tbl[0], 3'd2);
      step();
      drive_idle();
      hreset = 1'b1;
      n_checks++;
      if (rd_en !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_rd1_pre: got rd_en=%b, expected 1", rd_en);
      end
      step();
      n_checks++;
      if ({rd_en, wr_en, hreadyout, hresp, hrdata, rd_addr} !== {4'b0010, 64'h0}) begin
         n_fail++;
         $display("FAIL rst_in_rd1: got rd=%b wr=%b rdy=%b resp=%b hrdata=%h rd_addr=%h, expected 0 0 1 0 0 0",
                  rd_en, wr_en, hreadyout, hresp, hrdata, rd_addr);
      end
      hreset = 1'b0;
      step();
      n_checks++;
      if ({rd_en, wr_en, hreadyout, hrdata} !== {3'b001, 32'h0}) begin
         n_fail++;
         $display("FAIL rst_after: got rd=%b wr=%b rdy=%b hrdata=%h, expected 0 0 1 0",
                  rd_en, wr_en, hreadyout, hrdata);
      end
   endtask

   initial begin
      test_reset();
      test_word_write();
      test_word_read();
      test_byte_half_writes();
      test_errors();
      test_back_to_back();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
